pong_ball_engine: RTL

- Per-frame ball physics and scoring for the John Pong game core.
- Sits upstream of the pixel renderer and downstream of the paddle controllers and VGA timing.
- Advances ball position once per frame_tick and bounces it off the top/bottom walls and the paddle faces.
- Detects misses, keeps scores and runs the serve / point-hold / game-over sequence.

---
 rtl/pong_ball_engine.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/pong_ball_engine.sv
// Ball physics, paddle/wall bounces, scoring and serve/hold/game-over sequencing for the Pong core.
// Optional `define SPEEDUP_EN: horizontal speed rises by one per paddle hit, up to 2*SPEED.
module pong_ball_engine #(
  parameter int H_ACTIVE       = 640,
  parameter int V_ACTIVE       = 480,
  parameter int BALL_SIZE      = 8,
  parameter int PADDLE_W       = 8,
  parameter int PADDLE_H       = 64,
  parameter int LEFT_PADDLE_X  = 16,
  parameter int RIGHT_PADDLE_X = 616,
  parameter int SPEED          = 2,
  parameter int HOLD_FRAMES    = 60,
  parameter int WIN_SCORE      = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       frame_tick,
  input  logic       serve,
  input  logic [9:0] left_paddle_y,
  input  logic [9:0] right_paddle_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic       point_left,
  output logic       point_right,
  output logic       in_play,
  output logic       game_over
);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_SCORED, S_OVER} state_t;

  localparam int SPD_W  = $clog2(2 * SPEED + 1);
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

  localparam logic [9:0]        X_CENTRE  = 10'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0]        Y_CENTRE  = 10'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [10:0]       X_MAX     = 11'(H_ACTIVE - BALL_SIZE);
  localparam logic [10:0]       Y_MAX     = 11'(V_ACTIVE - BALL_SIZE);
  localparam logic [10:0]       FACE_R    = 11'(RIGHT_PADDLE_X - BALL_SIZE);
  localparam logic [10:0]       FACE_L    = 11'(LEFT_PADDLE_X + PADDLE_W);
  localparam logic [10:0]       SPD_Y     = 11'(SPEED);
  localparam logic [10:0]       BALL_E    = 11'(BALL_SIZE);
  localparam logic [10:0]       PAD_E     = 11'(PADDLE_H);
  localparam logic [3:0]        WIN       = 4'(WIN_SCORE);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

  state_t            state, state_next;
  logic              dir_right, dir_down, scorer_left;
  logic [HOLD_W-1:0] hold_cnt;
  logic [SPD_W-1:0]  spd_x;
  logic              tick, srv;
  logic              in_play_d, game_over_d;

  // ena gates every event so a disabled engine sees neither ticks nor serves.
  assign tick = ena & frame_tick;
  assign srv  = ena & serve;

  logic [10:0] x_ext, y_ext, spd_ext, x_fwd, lpy_ext, rpy_ext;
  logic        ovl_l, ovl_r, hit_r, hit_l, miss_r, miss_l, y_flip;
  logic [9:0]  x_new, y_new;

  // Motion and collision decode; 11-bit arithmetic keeps position+speed from wrapping.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    x_new   = ball_x;
    y_new   = ball_y;
    y_flip  = 1'b0;
    x_ext   = {1'b0, ball_x};
    y_ext   = {1'b0, ball_y};
    lpy_ext = {1'b0, left_paddle_y};
    rpy_ext = {1'b0, right_paddle_y};
    spd_ext = 11'(spd_x);
    x_fwd   = x_ext + spd_ext;

    ovl_r  = (y_ext + BALL_E > rpy_ext) && (y_ext < rpy_ext + PAD_E);
    ovl_l  = (y_ext + BALL_E > lpy_ext) && (y_ext < lpy_ext + PAD_E);
    hit_r  = dir_right && (x_fwd >= FACE_R) && (x_ext <= FACE_R) && ovl_r;
    hit_l  = !dir_right && (x_ext <= FACE_L + spd_ext) && (x_ext >= FACE_L) && ovl_l;
    miss_r = dir_right && !hit_r && (x_fwd > X_MAX);
    miss_l = !dir_right && !hit_l && (x_ext < spd_ext);

    if (hit_r)          x_new = FACE_R[9:0];
    else if (hit_l)     x_new = FACE_L[9:0];
    else if (dir_right) x_new = x_fwd[9:0];
    else                x_new = 10'(x_ext - spd_ext);

    if (dir_down) begin
      if (y_ext + SPD_Y >= Y_MAX) begin
        y_new  = Y_MAX[9:0];
        y_flip = 1'b1;
      end else begin
        y_new = 10'(y_ext + SPD_Y);
      end
    end else if (y_ext < SPD_Y) begin
      y_new  = '0;
      y_flip = 1'b1;
    end else begin
      y_new = 10'(y_ext - SPD_Y);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:   if (srv) state_next = S_PLAY;
      S_PLAY:   if (tick && (miss_r || miss_l)) state_next = S_SCORED;
      S_SCORED: if (tick && hold_cnt == HOLD_LAST)
                  state_next = ((scorer_left ? score_left : score_right) == WIN) ? S_OVER : S_IDLE;
      S_OVER:   if (srv) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_play_d   = (state_next == S_PLAY);
    game_over_d = (state_next == S_OVER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ball_x      <= X_CENTRE;
      ball_y      <= Y_CENTRE;
      score_left  <= '0;
      score_right <= '0;
      point_left  <= 1'b0;
      point_right <= 1'b0;
      in_play     <= 1'b0;
      game_over   <= 1'b0;
      dir_right   <= 1'b1;
      dir_down    <= 1'b1;
      scorer_left <= 1'b0;
      hold_cnt    <= '0;
    end else begin
      point_left  <= tick && (state == S_PLAY) && miss_r;
      point_right <= tick && (state == S_PLAY) && miss_l;
      in_play     <= in_play_d;
      game_over   <= game_over_d;
      case (state)
        S_PLAY: if (tick) begin
          // A point freezes the ball where it is and discards the vertical step.
          if (miss_r) begin
            if (score_left != WIN) score_left <= score_left + 4'd1;
            scorer_left <= 1'b1;
            dir_right   <= 1'b0;
            hold_cnt    <= '0;
          end else if (miss_l) begin
            if (score_right != WIN) score_right <= score_right + 4'd1;
            scorer_left <= 1'b0;
            dir_right   <= 1'b1;
            hold_cnt    <= '0;
          end else begin
            ball_x <= x_new;
            ball_y <= y_new;
            if (hit_r || hit_l) dir_right <= ~dir_right;
            if (y_flip)         dir_down  <= ~dir_down;
          end
        end
        S_SCORED: if (tick) begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt <= '0;
            ball_x   <= X_CENTRE;
            ball_y   <= Y_CENTRE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        S_OVER: if (srv) begin
          score_left  <= '0;
          score_right <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef SPEEDUP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      spd_x <= SPD_W'(SPEED);
    else if (srv && (state == S_IDLE || state == S_OVER))
      spd_x <= SPD_W'(SPEED);
    else if (tick && (state == S_PLAY) && (hit_r || hit_l) && (spd_x != SPD_W'(2 * SPEED)))
      spd_x <= spd_x + 1'b1;
  end
`else
  assign spd_x = SPD_W'(SPEED);
`endif

endmodule
